// File: rtl/prio_grant_arb_if.sv
// prio_grant_arb_if
//   Groups the request side and the valid/ready grant side of prio_grant_arb.
//   Parameters:
//     N     - number of request lines (>= 2)
//     CNT_W - width of the accepted-grant counter
//   Signals:
//     req        : request vector, bit i requests for source i
//     rr_mode    : 0 = fixed priority, 1 = round-robin
//     out_ready  : consumer accepts the current grant
//     out_valid  : grant registered and held
//     out_idx    : binary index of the granted source
//     out_onehot : one-hot form of out_idx
//     grant_cnt  : count of accepted grants
//   Modports:
//     slave  - arbiter side (drives the grant outputs)
//     master - request/consumer side (drives req, rr_mode, out_ready)
interface prio_grant_arb_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    localparam int W = $clog2(N);

    logic [N-1:0]     req;
    logic             rr_mode;
    logic             out_ready;
    logic             out_valid;
    logic [W-1:0]     out_idx;
    logic [N-1:0]     out_onehot;
    logic [CNT_W-1:0] grant_cnt;

    modport slave (
        input  req,
        input  rr_mode,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output grant_cnt
    );

    modport master (
        output req,
        output rr_mode,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  grant_cnt
    );
endinterface

// File: rtl/prio_grant_arb.sv
// prio_grant_arb
//   Registered N-way arbiter. Picks one requester by fixed priority (highest
//   index wins) or round-robin, and holds the grant with a valid/ready
//   handshake until the consumer accepts it. Back-to-back grants at one per
//   cycle are possible while requests keep arriving.
//   Ports:
//     clk    : sole clock, rising edge
//     areset : asynchronous, active-high reset
//     bus    : prio_grant_arb_if.slave (req, rr_mode, out_ready in;
//              out_valid, out_idx, out_onehot, grant_cnt out)
//   Build option:
//     PRIO_GRANT_RR_EN - when defined, compiles in the round-robin pointer and
//                        lets rr_mode select the policy; otherwise fixed
//                        priority only and rr_mode is ignored.
//
//   state | meaning
//   ------+-------------------------------------------
//   IDLE  | no grant presented, outputs cleared
//   HOLD  | grant registered, frozen until accepted
module prio_grant_arb #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 areset,
    prio_grant_arb_if.slave      bus
);
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q;
    logic [W-1:0]     idx_q;
    logic [N-1:0]     onehot_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             req_any;
    logic [W-1:0]     fix_win;
    logic [W-1:0]     win_d;
    logic [N-1:0]     onehot_d;

    assign accept  = (state_q == HOLD) && bus.out_ready;
    assign req_any = |bus.req;

    always_comb begin
        fix_win = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) fix_win = W'(i);
        end
    end

`ifdef PRIO_GRANT_RR_EN
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] rr_win;

    // On an accept edge the pointer is about to become out_idx, and the new
    // winner must already be searched from that updated pointer.
    assign ptr_eff = accept ? idx_q : ptr_q;

    // Descending search from ptr-1 (mod N); iterating from the far end lets
    // the nearest set bit overwrite the result last.
    always_comb begin
        rr_win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (bus.req[W'((int'(ptr_eff) + 2 * N - 1 - k) % N)])
                rr_win = W'((int'(ptr_eff) + 2 * N - 1 - k) % N);
        end
    end

    assign win_d = bus.rr_mode ? rr_win : fix_win;

    always_ff @(posedge clk or posedge areset) begin
        if (areset)      ptr_q <= '0;
        else if (accept) ptr_q <= idx_q;
    end
`else
    logic unused_rr_mode;
    assign unused_rr_mode = bus.rr_mode;
    assign win_d          = fix_win;
`endif

    assign onehot_d = {{(N-1){1'b0}}, 1'b1} << win_d;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            onehot_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        state_q  <= HOLD;
                        idx_q    <= win_d;
                        onehot_q <= onehot_d;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (req_any) begin
                            idx_q    <= win_d;
                            onehot_q <= onehot_d;
                        end else begin
                            state_q  <= IDLE;
                            idx_q    <= '0;
                            onehot_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    idx_q    <= '0;
                    onehot_q <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;
    assign bus.grant_cnt  = cnt_q;
endmodule
